// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: owner IDs, FSM states, request bundle.
package sram_arbiter_pkg;

    localparam logic ARB_ID_INST = 1'b0;
    localparam logic ARB_ID_DATA = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_HOLD_I = 2'd1,
        ARB_HOLD_D = 2'd2
    } arb_state_t;

    // Request fields that travel with req onto the shared port
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } sram_req_t;

    localparam int SRAM_REQ_WD = $bits(sram_req_t);

endpackage

// File: rtl/arb_owner_fifo.sv
// In-order FIFO of 1-bit owner IDs for transactions accepted but not yet returned.
module arb_owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_push,
    input  logic i_pop,
    input  logic i_id,
    output logic o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    function automatic logic [PTR_W-1:0] ptrNext(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_head   = r_mem[r_rdPtr];
    assign w_doPush = i_push & ~o_full;
    assign w_doPop  = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= ptrNext(r_wrPtr);
            if (w_doPop)  r_rdPtr <= ptrNext(r_rdPtr);
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mem <= '0;
        end else if (w_doPush) begin
            r_mem[r_wrPtr] <= i_id;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates the IF and data SRAM masters onto one in-order memory port.
// Define ARB_RR_EN for round-robin arbitration; default is fixed data-over-IF priority.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int OUTST_DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    arb_state_t r_state;
    arb_state_t w_stateNext;
    logic       w_sel;
    logic       w_grant;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic       w_head;
    logic       w_tieWinner;
    sram_req_t  w_instBundle;
    sram_req_t  w_dataBundle;
    sram_req_t  w_memBundle;

    assign w_instBundle = '{wr: inst_wr, size: inst_size, addr: inst_addr,
                            wstrb: inst_wstrb, wdata: inst_wdata};
    assign w_dataBundle = '{wr: data_wr, size: data_size, addr: data_addr,
                            wstrb: data_wstrb, wdata: data_wdata};

`ifdef ARB_RR_EN
    logic r_rrPrio;

    // Tie-break pointer names the master that wins the next simultaneous request
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rrPrio <= ARB_ID_DATA;
        end else if (w_push && inst_req && data_req) begin
            r_rrPrio <= ~w_sel;
        end
    end

    assign w_tieWinner = r_rrPrio;
`else
    assign w_tieWinner = ARB_ID_DATA;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // A held master keeps the port even if the other one requests; dropping req aborts without a push
    always_comb begin
        w_stateNext = r_state;
        w_sel       = ARB_ID_DATA;
        w_grant     = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (!w_full) begin
                    if (inst_req && data_req) w_sel = w_tieWinner;
                    else if (inst_req)        w_sel = ARB_ID_INST;
                    else                      w_sel = ARB_ID_DATA;
                    w_grant = inst_req | data_req;
                    if (w_grant) begin
                        if (mem_addr_ok) w_push = 1'b1;
                        else w_stateNext = (w_sel == ARB_ID_INST) ? ARB_HOLD_I : ARB_HOLD_D;
                    end
                end
            end
            ARB_HOLD_I: begin
                w_sel   = ARB_ID_INST;
                w_grant = inst_req;
                if (!inst_req) begin
                    w_stateNext = ARB_IDLE;
                end else if (mem_addr_ok) begin
                    w_push      = 1'b1;
                    w_stateNext = ARB_IDLE;
                end
            end
            ARB_HOLD_D: begin
                w_sel   = ARB_ID_DATA;
                w_grant = data_req;
                if (!data_req) begin
                    w_stateNext = ARB_IDLE;
                end else if (mem_addr_ok) begin
                    w_push      = 1'b1;
                    w_stateNext = ARB_IDLE;
                end
            end
            default: w_stateNext = ARB_IDLE;
        endcase
    end

    assign w_memBundle  = w_grant ? ((w_sel == ARB_ID_INST) ? w_instBundle : w_dataBundle) : '0;
    assign mem_req      = w_grant;
    assign mem_wr       = w_memBundle.wr;
    assign mem_size     = w_memBundle.size;
    assign mem_addr     = w_memBundle.addr;
    assign mem_wstrb    = w_memBundle.wstrb;
    assign mem_wdata    = w_memBundle.wdata;
    assign inst_addr_ok = w_push & (w_sel == ARB_ID_INST);
    assign data_addr_ok = w_push & (w_sel == ARB_ID_DATA);

    // Responses with nothing outstanding are dropped
    assign w_pop        = mem_data_ok & ~w_empty;
    assign inst_data_ok = w_pop & (w_head == ARB_ID_INST);
    assign data_data_ok = w_pop & (w_head == ARB_ID_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    arb_owner_fifo #(
        .DEPTH (OUTST_DEPTH)
    ) u_ownerFifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_id    (w_sel),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed testbench for sram_arbiter (default fixed-priority build, OUTST_DEPTH=2).
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.OUTST_DEPTH(2)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where new inputs are applied
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0;
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wstrb = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;

        sample();
        checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        checkOutput("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        applyStimulus();
        resetn = 1'b1;
        applyStimulus();

        // Both request with immediate acceptance: data first, IF next cycle
        inst_req = 1; inst_addr = 32'h0000_1000;
        data_req = 1; data_addr = 32'h0000_2000; data_wr = 1; data_wstrb = 4'hf; data_wdata = 32'hdead_beef;
        mem_addr_ok = 1;
        sample();
        checkOutput("tie_mem_addr", mem_addr, 32'h0000_2000);
        checkOutput("tie_mem_wdata", mem_wdata, 32'hdead_beef);
        checkOutput("tie_mem_wr", {31'd0, mem_wr}, 32'd1);
        checkOutput("tie_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
        applyStimulus();
        data_req = 0; data_wr = 0; data_wstrb = 0; data_wdata = 0;
        sample();
        checkOutput("tie2_mem_addr", mem_addr, 32'h0000_1000);
        checkOutput("tie2_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
        applyStimulus();
        inst_req = 0; mem_addr_ok = 0;
        mem_data_ok = 1; mem_rdata = 32'haaaa_aaaa;
        sample();
        checkOutput("ret1_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd1);
        checkOutput("ret1_rdata", data_rdata, 32'haaaa_aaaa);
        applyStimulus();
        mem_rdata = 32'hbbbb_bbbb;
        sample();
        checkOutput("ret2_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
        checkOutput("ret2_rdata", inst_rdata, 32'hbbbb_bbbb);
        applyStimulus();
        mem_data_ok = 0; mem_rdata = 0;

        // IF held for 3 cycles while data waits
        inst_req = 1; inst_addr = 32'hbfc0_0000;
        sample();
        checkOutput("hold0_mem_addr", mem_addr, 32'hbfc0_0000);
        checkOutput("hold0_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        applyStimulus();
        data_req = 1; data_addr = 32'h0000_3000;
        sample();
        checkOutput("hold1_mem_addr", mem_addr, 32'hbfc0_0000);
        checkOutput("hold1_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        applyStimulus();
        sample();
        checkOutput("hold2_mem_addr", mem_addr, 32'hbfc0_0000);
        applyStimulus();
        mem_addr_ok = 1;
        sample();
        checkOutput("hold3_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
        checkOutput("hold3_mem_addr", mem_addr, 32'hbfc0_0000);
        applyStimulus();
        inst_req = 0;
        sample();
        checkOutput("hold4_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
        checkOutput("hold4_mem_addr", mem_addr, 32'h0000_3000);
        applyStimulus();
        data_req = 0; mem_addr_ok = 0;
        mem_data_ok = 1; mem_rdata = 32'h1111_1111;
        sample();
        checkOutput("ord1_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
        checkOutput("ord1_rdata", inst_rdata, 32'h1111_1111);
        applyStimulus();
        mem_rdata = 32'h2222_2222;
        sample();
        checkOutput("ord2_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd1);
        checkOutput("ord2_rdata", data_rdata, 32'h2222_2222);
        applyStimulus();
        mem_data_ok = 0; mem_rdata = 0;

        // Fill the owner FIFO; third request waits for a pop and goes the cycle after
        inst_req = 1; inst_addr = 32'h0000_0010; mem_addr_ok = 1;
        sample();
        checkOutput("full_a_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        applyStimulus();
        inst_addr = 32'h0000_0014;
        sample();
        checkOutput("full_b_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        applyStimulus();
        inst_addr = 32'h0000_0018;
        sample();
        checkOutput("full_c_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("full_c_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        checkOutput("full_c_mem_addr", mem_addr, 32'd0);
        applyStimulus();
        mem_data_ok = 1; mem_rdata = 32'h0000_0005;
        sample();
        checkOutput("full_pop_data_ok", {31'd0, inst_data_ok}, 32'd1);
        checkOutput("full_pop_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        checkOutput("full_pop_mem_req", {31'd0, mem_req}, 32'd0);
        applyStimulus();
        mem_data_ok = 0; mem_rdata = 0;
        sample();
        checkOutput("full_after_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        checkOutput("full_after_mem_addr", mem_addr, 32'h0000_0018);
        applyStimulus();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        sample();
        checkOutput("drain1_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
        applyStimulus();
        sample();
        checkOutput("drain2_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
        applyStimulus();
        mem_data_ok = 0;

        // IF hold aborted by a flush; data granted the cycle after
        inst_req = 1; inst_addr = 32'h0000_0040;
        applyStimulus();
        data_req = 1; data_addr = 32'h0000_0050;
        sample();
        checkOutput("flush1_mem_addr", mem_addr, 32'h0000_0040);
        applyStimulus();
        inst_req = 0;
        sample();
        checkOutput("flush2_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("flush2_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        applyStimulus();
        mem_addr_ok = 1;
        sample();
        checkOutput("flush3_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
        checkOutput("flush3_mem_addr", mem_addr, 32'h0000_0050);
        applyStimulus();
        data_req = 0; inst_req = 1; inst_addr = 32'h0000_0060;
        sample();
        checkOutput("flush4_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
        applyStimulus();
        inst_req = 0; mem_addr_ok = 0;

        // Reset with two outstanding; a stray response afterwards must be ignored
        resetn = 0;
        sample();
        checkOutput("rst2_mem_req", {31'd0, mem_req}, 32'd0);
        applyStimulus();
        applyStimulus();
        resetn = 1;
        applyStimulus();
        mem_data_ok = 1; mem_rdata = 32'h0;
        sample();
        checkOutput("stray_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        checkOutput("stray_mem_req", {31'd0, mem_req}, 32'd0);
        applyStimulus();
        mem_data_ok = 0;
        data_req = 1; data_addr = 32'h0000_0070; mem_addr_ok = 1;
        sample();
        checkOutput("post_rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
        applyStimulus();
        data_req = 0; mem_addr_ok = 0;
        applyStimulus();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
